serial_sub: RTL and testbench

- Bit-serial subtractor: the inverse-direction counterpart of the team's full-adder datapath.
- Computes diff = a - b - bin over WIDTH clock cycles, LSB first, using one full-subtractor cell and a registered borrow.
- Sits behind a simple start/busy/done handshake so an area-constrained controller can issue subtractions without a WIDTH-bit ripple chain.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_if.sv | 23 ++
 rtl/serial_sub_fs_cell.sv | 11 +
 rtl/serial_sub.sv | 103 ++++++++++
 tb/tb_serial_sub.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bit counter must reach WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bus for the serial subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_fs_cell.sv
// Combinational full subtractor: d = x - y - bi, with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one fs_cell plus a registered borrow, LSB first over WIDTH cycles.
//   state   | meaning
//   IDLE    | waiting for start; diff/bout hold last result
//   RUN     | one operand bit per clock, busy high
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  serial_sub_if.slave bus
);
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, a_d;
  logic [WIDTH-1:0] b_sh, b_d;
  logic [WIDTH-1:0] res_sh, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             cell_d, cell_bo;

  fs_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh     <= a_d;
      b_sh     <= b_d;
      res_sh   <= res_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_sh;
    b_d      = b_sh;
    res_d    = res_sh;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d      = a_sh >> 1;
        b_d      = b_sh >> 1;
        res_d    = {cell_d, res_sh[WIDTH-1:1]};
        borrow_d = cell_bo;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          // Publish the word including this final bit; counter parks at 0.
          diff_d  = res_d;
          bout_d  = cell_bo;
          done_d  = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8) and the standalone fs_cell.
module tb_serial_sub;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  serial_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic fx, fy, fbi, fd, fbo;
  fs_cell u_fs (
    .x  (fx),
    .y  (fy),
    .bi (fbi),
    .d  (fd),
    .bo (fbo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a start request at the current sample point, drop it after one edge.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    bus.bin   = tbin;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Count busy samples until done is observed; bounded.
  task automatic wait_done(output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.busy, bus.done, bus.bout} !== 3'b000 || bus.diff !== 8'h00)
      $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b, required all 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    else n_pass++;
  endtask

  task automatic test_fs_cell();
    logic [1:0] exp_tab [8];
    logic [2:0] v;
    exp_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {fx, fy, fbi} = v;
      #1;
      n_total++;
      if ({fd, fbo} !== exp_tab[i])
        $display("FAIL fs_cell_%0d: d,bo=%b%b, required %b", i, fd, fbo, exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int bc; bit seen;
    issue(8'h5A, 8'h3C, 1'b0);
    wait_done(bc, seen);
    n_total++;
    if (!seen || bc != WIDTH) $display("FAIL basic_timing: done_seen=%0b busy_cycles=%0d, required 1/%0d", seen, bc, WIDTH);
    else n_pass++;
    n_total++;
    if (bus.diff !== 8'h1E || bus.bout !== 1'b0) $display("FAIL basic_result: diff=%h bout=%b, required 1e/0", bus.diff, bus.bout);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL basic_done_pulse: done=%b busy=%b, required 0/0", bus.done, bus.busy);
    else n_pass++;
  endtask

  task automatic test_borrow();
    int bc; bit seen;
    issue(8'h00, 8'h01, 1'b0);
    wait_done(bc, seen);
    n_total++;
    if (!seen || bus.diff !== 8'hFF || bus.bout !== 1'b1) $display("FAIL borrow_underflow: seen=%0b diff=%h bout=%b, required 1/ff/1", seen, bus.diff, bus.bout);
    else n_pass++;
    @(posedge clk); #1;
    issue(8'h10, 8'h10, 1'b1);
    wait_done(bc, seen);
    n_total++;
    if (!seen || bus.diff !== 8'hFF || bus.bout !== 1'b1) $display("FAIL borrow_in: seen=%0b diff=%h bout=%b, required 1/ff/1", seen, bus.diff, bus.bout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int dones; bit rebusy;
    dones  = 0;
    rebusy = 1'b0;
    issue(8'h80, 8'h01, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.done) dones++;
      if (dones > 0 && bus.busy) rebusy = 1'b1;
      @(posedge clk); #1;
    end
    n_total++;
    if (dones != 1 || rebusy) $display("FAIL ignore_done_count: dones=%0d rebusy=%0b, required 1/0", dones, rebusy);
    else n_pass++;
    n_total++;
    if (bus.diff !== 8'h7F || bus.bout !== 1'b0) $display("FAIL ignore_result: diff=%h bout=%b, required 7f/0", bus.diff, bus.bout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bc; bit seen; int dones;
    dones = 0;
    issue(8'h5A, 8'h3C, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.busy, bus.done, bus.bout} !== 3'b000 || bus.diff !== 8'h00)
      $display("FAIL reset_mid_async: busy=%b done=%b diff=%h bout=%b, required all 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) dones++;
      @(posedge clk); #1;
    end
    n_total++;
    if (dones != 0) $display("FAIL reset_mid_no_done: activity_cycles=%0d, required 0", dones);
    else n_pass++;
    issue(8'h03, 8'h05, 1'b0);
    wait_done(bc, seen);
    n_total++;
    if (!seen || bus.diff !== 8'hFE || bus.bout !== 1'b1) $display("FAIL reset_mid_recover: seen=%0b diff=%h bout=%b, required 1/fe/1", seen, bus.diff, bus.bout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bc; bit seen;
    bus.start = 1'b1; bus.a = 8'h22; bus.b = 8'h11; bus.bin = 1'b0;
    @(posedge clk); #1;
    wait_done(bc, seen);
    n_total++;
    if (!seen || bus.diff !== 8'h11 || bus.bout !== 1'b0) $display("FAIL b2b_first: seen=%0b diff=%h bout=%b, required 1/11/0", seen, bus.diff, bus.bout);
    else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL b2b_accept: busy=%b done=%b, required 1/0", bus.busy, bus.done);
    else n_pass++;
    wait_done(bc, seen);
    n_total++;
    if (!seen || bc != WIDTH || bus.diff !== 8'h11 || bus.bout !== 1'b0)
      $display("FAIL b2b_second: seen=%0b busy_cycles=%0d diff=%h bout=%b, required 1/%0d/11/0", seen, bc, bus.diff, bus.bout, WIDTH);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    fx = 1'b0; fy = 1'b0; fbi = 1'b0;
    #12;
    test_reset();
    test_fs_cell();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_borrow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
